// File: rtl/usb_rx_bit_decoder.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_bit_decoder
// Description : Full-speed USB receive bit decoder. Synchronizes D+/D-,
//               NRZI-decodes on each sample strobe from the bit-period
//               counter, strips stuffed bits, detects SYNC and EOP and
//               assembles bytes LSB-first. Drives the counter's restart
//               (resync) and enable (rx_active).
//               Optional macro RX_SYNC_STRICT_EN: when defined, SYNC must
//               carry exactly 7 decoded zeros before its terminating '1'.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_bit_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_SYNC_ZEROS = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dp_in,
  input  logic       dm_in,
  input  logic       sample_strobe,
  output logic       resync,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       eop,
  output logic       stuff_err,
  output logic       frame_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_EOP  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  // Normalized line symbols {dp, dm}; SE1 folds into SE0.
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  logic [SYNC_STAGES-1:0] dp_sync;
  logic [SYNC_STAGES-1:0] dm_sync;
  logic                   dp_s;
  logic                   dm_s;
  logic                   dp_dly;
  logic                   line_edge;
  logic                   is_se0;
  logic                   is_j;
  logic                   is_k;
  logic [1:0]             line_n;
  logic [1:0]             prev_line;
  logic                   nrzi_bit;
  logic [2:0]             state;
  logic [3:0]             zero_cnt;
  logic [2:0]             ones_cnt;
  logic [2:0]             bit_cnt;
  logic [1:0]             se0_cnt;
  logic [7:0]             shreg;
  logic [7:0]             shifted;
  logic                   err_se0_seen;
  logic                   sync_ok;

  // Multi-flop synchronizers; reset to the idle J line state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_sync <= '1;
      dm_sync <= '0;
      dp_dly  <= 1'b1;
    end else begin
      dp_sync <= {dp_sync[SYNC_STAGES-2:0], dp_in};
      dm_sync <= {dm_sync[SYNC_STAGES-2:0], dm_in};
      dp_dly  <= dp_sync[SYNC_STAGES-1];
    end
  end

  assign dp_s      = dp_sync[SYNC_STAGES-1];
  assign dm_s      = dm_sync[SYNC_STAGES-1];
  assign line_edge = dp_s ^ dp_dly;
  assign is_se0    = (dp_s == dm_s);
  assign is_j      = dp_s & ~dm_s;
  assign is_k      = ~dp_s & dm_s;
  assign line_n    = is_se0 ? LINE_SE0 : {dp_s, dm_s};
  // NRZI: no transition since the previous sample means a '1'.
  assign nrzi_bit  = (line_n == prev_line);
  assign shifted   = {nrzi_bit, shreg[7:1]};
  assign rx_active = (state == ST_SYNC) || (state == ST_DATA) || (state == ST_EOP);

`ifdef RX_SYNC_STRICT_EN
  // Only the canonical KJKJKJKK pattern (7 zeros then a one) is accepted.
  assign sync_ok = (zero_cnt == 4'd7);
`else
  localparam logic [3:0] MIN_ZEROS = 4'(MIN_SYNC_ZEROS);
  // Any zero run from the configured minimum up to 7 is accepted.
  assign sync_ok = (zero_cnt >= MIN_ZEROS);
`endif

  // Receive state machine, counters, byte assembly and output pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= ST_IDLE;
      prev_line     <= LINE_J;
      zero_cnt      <= 4'd0;
      ones_cnt      <= 3'd0;
      bit_cnt       <= 3'd0;
      se0_cnt       <= 2'd0;
      shreg         <= 8'h00;
      err_se0_seen  <= 1'b0;
      rx_data       <= 8'h00;
      rx_data_valid <= 1'b0;
      eop           <= 1'b0;
      stuff_err     <= 1'b0;
      frame_err     <= 1'b0;
      resync        <= 1'b0;
    end else begin
      resync        <= line_edge && ((state == ST_IDLE) || (state == ST_SYNC) ||
                                     (state == ST_DATA));
      rx_data_valid <= 1'b0;
      eop           <= 1'b0;
      stuff_err     <= 1'b0;
      frame_err     <= 1'b0;
      if (sample_strobe) begin
        prev_line <= line_n;
      end
      if (state != ST_ERR) begin
        err_se0_seen <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          prev_line <= LINE_J;
          zero_cnt  <= 4'd0;
          if (is_k) begin
            state <= ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (sample_strobe) begin
            if (is_se0) begin
              frame_err <= 1'b1;
              state     <= ST_ERR;
            end else if (!nrzi_bit) begin
              // An eighth zero can never be a valid SYNC.
              if (zero_cnt == 4'd7) begin
                frame_err <= 1'b1;
                state     <= ST_ERR;
              end else begin
                zero_cnt <= zero_cnt + 4'd1;
              end
            end else if (sync_ok) begin
              // The SYNC terminating '1' starts the stuffing run.
              state    <= ST_DATA;
              ones_cnt <= 3'd1;
              bit_cnt  <= 3'd0;
              shreg    <= 8'h00;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_ERR;
            end
          end
        end

        ST_DATA: begin
          if (sample_strobe) begin
            if (is_se0) begin
              state   <= ST_EOP;
              se0_cnt <= 2'd1;
            end else if (ones_cnt == 3'd6) begin
              if (nrzi_bit) begin
                stuff_err <= 1'b1;
                state     <= ST_ERR;
              end else begin
                ones_cnt <= 3'd0;
              end
            end else begin
              shreg    <= shifted;
              ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data       <= shifted;
                rx_data_valid <= 1'b1;
              end
            end
          end
        end

        ST_EOP: begin
          if (sample_strobe) begin
            if (is_se0) begin
              if (se0_cnt == 2'd2) begin
                frame_err <= 1'b1;
                state     <= ST_ERR;
              end else begin
                se0_cnt <= se0_cnt + 2'd1;
              end
            end else if (is_j) begin
              // A packet ending off a byte boundary is still closed, but flagged.
              eop       <= 1'b1;
              frame_err <= (bit_cnt != 3'd0);
              state     <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_ERR;
            end
          end
        end

        ST_ERR: begin
          // Recovery needs SE0 immediately followed by J; strobes are ignored.
          if (is_se0) begin
            err_se0_seen <= 1'b1;
          end else if (is_j && err_se0_seen) begin
            err_se0_seen <= 1'b0;
            state        <= ST_IDLE;
          end else if (is_k) begin
            err_se0_seen <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_bit_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_usb_rx_bit_decoder
// Description : Self-checking bench for usb_rx_bit_decoder. Packets are
//               built from byte lists (bit stuffing + NRZI encoding) and
//               expected results follow directly from the packet contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_bit_decoder;

  localparam logic [1:0] SYM_J   = 2'd0;
  localparam logic [1:0] SYM_K   = 2'd1;
  localparam logic [1:0] SYM_SE0 = 2'd2;

`ifdef RX_SYNC_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       dp_in = 1'b1;
  logic       dm_in = 1'b0;
  logic       sample_strobe = 1'b0;
  logic       resync;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       eop;
  logic       stuff_err;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  // Monitor-owned counters
  logic [7:0] got[$];
  int eop_cnt = 0, stuff_cnt = 0, ferr_cnt = 0, eop_ferr_cnt = 0;
  int resync_cnt = 0, active_cnt = 0;

  // Snapshots taken by the tests
  int s_bytes, s_eop, s_stuff, s_ferr, s_eop_ferr, s_active;

  // Packet builder inputs and output
  logic [7:0] tx_bytes[$];
  int         tx_extra;
  int         tx_nz;
  bit         tx_stuff;
  int         tx_nse0;
  logic [1:0] syms[$];

  usb_rx_bit_decoder #(.SYNC_STAGES(2), .MIN_SYNC_ZEROS(3)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .dp_in         (dp_in),
    .dm_in         (dm_in),
    .sample_strobe (sample_strobe),
    .resync        (resync),
    .rx_active     (rx_active),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .eop           (eop),
    .stuff_err     (stuff_err),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  // Observe DUT pulses away from the active edge
  always @(negedge clk) begin
    if (rx_data_valid) got.push_back(rx_data);
    if (eop) eop_cnt++;
    if (stuff_err) stuff_cnt++;
    if (frame_err) ferr_cnt++;
    if (eop && frame_err) eop_ferr_cnt++;
    if (resync) resync_cnt++;
    if (rx_active) active_cnt++;
  end

  task automatic snap();
    s_bytes = got.size(); s_eop = eop_cnt; s_stuff = stuff_cnt;
    s_ferr = ferr_cnt; s_eop_ferr = eop_ferr_cnt; s_active = active_cnt;
  endtask

  // One bit period of 8 clocks with the strobe near the middle
  task automatic drive_sym(input logic [1:0] s);
    case (s)
      SYM_J:   {dp_in, dm_in} = 2'b10;
      SYM_K:   {dp_in, dm_in} = 2'b01;
      default: {dp_in, dm_in} = 2'b00;
    endcase
    repeat (4) @(negedge clk);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_sym(SYM_J);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive_sym(syms[i]);
  endtask

  // Reference encoder: SYNC zeros + '1', LSB-first data, stuffing after
  // six consecutive ones (the SYNC '1' included), NRZI, SE0s, J.
  task automatic build_packet();
    bit         dbits[$];
    bit         raw[$];
    int         run;
    logic [1:0] lvl;
    logic [7:0] b;
    syms.delete();
    foreach (tx_bytes[k]) begin
      b = tx_bytes[k];
      for (int i = 0; i < 8; i++) dbits.push_back(b[i]);
    end
    for (int i = 0; i < tx_extra; i++) dbits.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < tx_nz; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    run = 1;
    foreach (dbits[i]) begin
      raw.push_back(dbits[i]);
      run = dbits[i] ? run + 1 : 0;
      if (tx_stuff && run == 6) begin
        raw.push_back(1'b0);
        run = 0;
      end
    end
    lvl = SYM_J;
    foreach (raw[i]) begin
      if (!raw[i]) lvl = (lvl == SYM_J) ? SYM_K : SYM_J;
      syms.push_back(lvl);
    end
    for (int i = 0; i < tx_nse0; i++) syms.push_back(SYM_SE0);
    syms.push_back(SYM_J);
  endtask

  task automatic set_pkt(input int nbytes, input int extra, input int nz);
    tx_bytes.delete();
    for (int i = 0; i < nbytes; i++)
      tx_bytes.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
    tx_extra = extra; tx_nz = nz; tx_stuff = 1'b1; tx_nse0 = 2;
  endtask

  // Compare a finished well-formed packet against tx_bytes/tx_extra
  task automatic check_good(input string name);
    int exp_ferr;
    exp_ferr = (tx_extra % 8 != 0) ? 1 : 0;
    checks++;
    if (got.size() - s_bytes !== tx_bytes.size()) begin
      errors++;
      $display("FAIL %s byte_count got %0d want %0d", name, got.size() - s_bytes, tx_bytes.size());
    end else begin
      foreach (tx_bytes[i]) begin
        checks++;
        if (got[s_bytes + i] !== tx_bytes[i]) begin
          errors++;
          $display("FAIL %s byte%0d got %h want %h", name, i, got[s_bytes + i], tx_bytes[i]);
        end
      end
    end
    checks++;
    if (eop_cnt - s_eop !== 1) begin
      errors++; $display("FAIL %s eop got %0d want 1", name, eop_cnt - s_eop);
    end
    checks++;
    if (ferr_cnt - s_ferr !== exp_ferr || eop_ferr_cnt - s_eop_ferr !== exp_ferr) begin
      errors++;
      $display("FAIL %s frame_err got %0d/%0d want %0d", name, ferr_cnt - s_ferr,
               eop_ferr_cnt - s_eop_ferr, exp_ferr);
    end
    checks++;
    if (stuff_cnt - s_stuff !== 0) begin
      errors++; $display("FAIL %s stuff_err got %0d want 0", name, stuff_cnt - s_stuff);
    end
    checks++;
    if (rx_active !== 1'b0) begin
      errors++; $display("FAIL %s rx_active_idle got %b want 0", name, rx_active);
    end
  endtask

  task automatic send_and_check(input string name);
    build_packet();
    snap();
    send_range(0, syms.size() - 1);
    idle(2);
    check_good(name);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({resync, rx_active, rx_data, rx_data_valid, eop, stuff_err, frame_err} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {resync, rx_active, rx_data, rx_data_valid, eop, stuff_err, frame_err});
    end
    n_rst = 1'b1;
    idle(3);
    checks++;
    if (rx_active !== 1'b0) begin
      errors++; $display("FAIL reset_idle rx_active got %b want 0", rx_active);
    end
  endtask

  task automatic test_basic();
    int r0;
    set_pkt(0, 0, 7);
    tx_bytes.push_back(8'hA5);
    build_packet();
    snap();
    r0 = resync_cnt;
    drive_sym(syms[0]);
    checks++;
    if (resync_cnt - r0 !== 1) begin
      errors++; $display("FAIL basic_resync got %0d want 1", resync_cnt - r0);
    end
    send_range(1, syms.size() - 1);
    idle(2);
    check_good("basic_a5");
    checks++;
    if (active_cnt - s_active <= 0) begin
      errors++; $display("FAIL basic_active got %0d want >0", active_cnt - s_active);
    end
  endtask

  task automatic test_stuffing();
    set_pkt(0, 0, 7);
    tx_bytes.push_back(8'hFF);
    tx_bytes.push_back(8'hFF);
    send_and_check("stuff_ff_ff");
  endtask

  task automatic test_stuff_error();
    set_pkt(0, 0, 7);
    tx_bytes.push_back(8'hFF);
    tx_stuff = 1'b0;
    build_packet();
    snap();
    // 8 SYNC symbols + 6 data ones: the sixth data one violates stuffing
    send_range(0, 13);
    checks++;
    if (stuff_cnt - s_stuff !== 1 || ferr_cnt - s_ferr !== 0) begin
      errors++;
      $display("FAIL stuff_error stuff/frame got %0d/%0d want 1/0", stuff_cnt - s_stuff,
               ferr_cnt - s_ferr);
    end
    checks++;
    if (rx_active !== 1'b0) begin
      errors++; $display("FAIL stuff_error_active got %b want 0", rx_active);
    end
    send_range(14, syms.size() - 1);
    idle(2);
    checks++;
    if (got.size() - s_bytes !== 0 || eop_cnt - s_eop !== 0 || stuff_cnt - s_stuff !== 1) begin
      errors++;
      $display("FAIL stuff_error_after bytes/eop/stuff got %0d/%0d/%0d want 0/0/1",
               got.size() - s_bytes, eop_cnt - s_eop, stuff_cnt - s_stuff);
    end
    set_pkt(2, 0, 7);
    send_and_check("after_stuff_err");
  endtask

  // SYNC zero-count acceptance, covering the 4-zero case and random counts
  task automatic sync_case(input int nz, input string name);
    bit ok;
    int exp_bytes;
    ok = STRICT ? (nz == 7) : (nz >= 3 && nz <= 7);
    set_pkt(1, 0, nz);
    build_packet();
    snap();
    send_range(0, syms.size() - 1);
    idle(2);
    exp_bytes = ok ? 1 : 0;
    checks++;
    if (got.size() - s_bytes !== exp_bytes || eop_cnt - s_eop !== exp_bytes ||
        ferr_cnt - s_ferr !== 1 - exp_bytes) begin
      errors++;
      $display("FAIL %s nz=%0d bytes/eop/ferr got %0d/%0d/%0d want %0d/%0d/%0d", name, nz,
               got.size() - s_bytes, eop_cnt - s_eop, ferr_cnt - s_ferr,
               exp_bytes, exp_bytes, 1 - exp_bytes);
    end else if (ok) begin
      checks++;
      if (got[s_bytes] !== tx_bytes[0]) begin
        errors++; $display("FAIL %s data got %h want %h", name, got[s_bytes], tx_bytes[0]);
      end
    end
    checks++;
    if (rx_active !== 1'b0) begin
      errors++; $display("FAIL %s rx_active got %b want 0", name, rx_active);
    end
  endtask

  task automatic test_sync_length();
    sync_case(4, "sync_4zeros");
    sync_case(2, "sync_2zeros");
    sync_case(8, "sync_8zeros");
    for (int i = 0; i < 5; i++) sync_case($urandom_range(1, 8), "sync_rand");
  endtask

  task automatic test_eop_misaligned();
    set_pkt(1, 4, 7);
    send_and_check("eop_12bits");
  endtask

  task automatic test_eop_long();
    set_pkt(1, 0, 7);
    tx_nse0 = 3;
    build_packet();
    snap();
    send_range(0, syms.size() - 1);
    idle(2);
    checks++;
    if (got.size() - s_bytes !== 1 || eop_cnt - s_eop !== 0 || ferr_cnt - s_ferr !== 1) begin
      errors++;
      $display("FAIL eop_3se0 bytes/eop/ferr got %0d/%0d/%0d want 1/0/1",
               got.size() - s_bytes, eop_cnt - s_eop, ferr_cnt - s_ferr);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      set_pkt($urandom_range(1, 3), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7), 7);
      send_and_check("b2b");
    end
  endtask

  task automatic test_reset_mid();
    set_pkt(2, 0, 7);
    build_packet();
    send_range(0, 11);
    #2;
    n_rst = 1'b0;
    {dp_in, dm_in} = 2'b10;
    #1;
    checks++;
    if ({resync, rx_active, rx_data, rx_data_valid, eop, stuff_err, frame_err} !== 14'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %h want 0",
               {resync, rx_active, rx_data, rx_data_valid, eop, stuff_err, frame_err});
    end
    repeat (4) @(negedge clk);
    n_rst = 1'b1;
    idle(3);
    set_pkt(2, 0, 7);
    send_and_check("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuffing();
    test_stuff_error();
    test_sync_length();
    test_eop_misaligned();
    test_eop_long();
    set_pkt(1, 0, 7);
    send_and_check("after_eop_err");
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
